// File: rtl/apb_slave_regbank.sv
// APB slave register bank: NUM_REGS x 32-bit registers with optional wait states,
// address/alignment error reporting and a registered write-commit strobe.
module apb_slave_regbank #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned NUM_REGS    = 20,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    i_PADDR,
  input  logic                     i_PSEL,
  input  logic                     i_PENABLE,
  input  logic                     i_PWRITE,
  input  logic [31:0]              i_PWDATA,
  output logic [31:0]              o_PRDATA,
  output logic                     o_PREADY,
  output logic                     o_PSLVERR,
  output logic [NUM_REGS*32-1:0]   o_regs,
  output logic                     o_wr_stb,
  output logic [7:0]               o_wr_idx
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] regs_q [NUM_REGS];
  logic        wr_stb_q;
  logic [7:0]  wr_idx_q;

  logic [31:0] paddr_idx;
  logic        setup_err;
  logic        complete;
  logic        commit;
  logic [31:0] rd_word;

  // Full-width index so out-of-range addresses beyond 8 bits still flag an error.
  assign paddr_idx = 32'(i_PADDR[ADDR_WIDTH-1:2]);
  assign setup_err = (i_PADDR[1:0] != 2'b00) || (paddr_idx >= NUM_REGS);

  assign complete = (state_q == StAccess) && (cnt_q == 4'd0);
  assign commit   = complete && write_q && !err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_PSEL && !i_PENABLE) begin
          state_d = StAccess;
          cnt_d   = WaitInit;
          idx_d   = paddr_idx[7:0];
          write_d = i_PWRITE;
          wdata_d = i_PWDATA;
          err_d   = setup_err;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else if (!i_PSEL) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_q == 8'(k)) rd_word = regs_q[k];
    end
  end

  assign o_PREADY  = complete;
  assign o_PSLVERR = complete && err_q;
  assign o_PRDATA  = (complete && !write_q && !err_q) ? rd_word : 32'd0;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_idx  = wr_idx_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_img
    assign o_regs[32*g +: 32] = regs_q[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= 8'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= 8'd0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      wr_stb_q <= commit;
      if (commit) begin
        wr_idx_q <= idx_q;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (idx_q == 8'(k)) regs_q[k] <= wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances (0, 2, 3 wait states), each with its
// own APB bus, checked against a register-array model of the bank.
module tb_apb_slave_regbank;

  localparam int unsigned AW = 10;
  localparam int unsigned NR = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [3];
  logic [AW-1:0] paddr   [3];
  logic          psel    [3];
  logic          penable [3];
  logic          pwrite  [3];
  logic [31:0]   pwdata  [3];
  logic [31:0]   prdata  [3];
  logic          pready  [3];
  logic          pslverr [3];
  logic [NR*32-1:0] regs [3];
  logic          wr_stb  [3];
  logic [7:0]    wr_idx  [3];

  logic [31:0] model [3][NR];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stb_cnt0 = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (wr_stb[0]) stb_cnt0 <= stb_cnt0 + 1;

  apb_slave_regbank #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .i_PADDR(paddr[0]), .i_PSEL(psel[0]), .i_PENABLE(penable[0]),
    .i_PWRITE(pwrite[0]), .i_PWDATA(pwdata[0]), .o_PRDATA(prdata[0]), .o_PREADY(pready[0]),
    .o_PSLVERR(pslverr[0]), .o_regs(regs[0]), .o_wr_stb(wr_stb[0]), .o_wr_idx(wr_idx[0])
  );
  apb_slave_regbank #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst[1]), .i_PADDR(paddr[1]), .i_PSEL(psel[1]), .i_PENABLE(penable[1]),
    .i_PWRITE(pwrite[1]), .i_PWDATA(pwdata[1]), .o_PRDATA(prdata[1]), .o_PREADY(pready[1]),
    .o_PSLVERR(pslverr[1]), .o_regs(regs[1]), .o_wr_stb(wr_stb[1]), .o_wr_idx(wr_idx[1])
  );
  apb_slave_regbank #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst[2]), .i_PADDR(paddr[2]), .i_PSEL(psel[2]), .i_PENABLE(penable[2]),
    .i_PWRITE(pwrite[2]), .i_PWDATA(pwdata[2]), .o_PRDATA(prdata[2]), .o_PREADY(pready[2]),
    .o_PSLVERR(pslverr[2]), .o_regs(regs[2]), .o_wr_stb(wr_stb[2]), .o_wr_idx(wr_idx[2])
  );

  function automatic int wait_of(input int d);
    case (d)
      0: return 0;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [NR*32-1:0] image(input int d);
    logic [NR*32-1:0] img;
    for (int k = 0; k < NR; k++) img[k*32 +: 32] = model[d][k];
    return img;
  endfunction

  // One full transfer starting from a point inside a cycle; returns at the negedge of
  // completion+1 after checking the write-commit side effects.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int comp_cyc);
    logic err;
    int idx;
    int waits;
    int setup_cyc;
    logic done;
    logic [31:0] exp_rd;
    idx = int'(a >> 2);
    err = (a[1:0] != 2'b00) || (idx >= int'(NR));
    exp_rd = (!wr && !err) ? model[d][idx] : 32'd0;
    setup_cyc = cyc;
    comp_cyc = 0;
    rd = 32'd0;
    paddr[d] = a; pwrite[d] = wr; pwdata[d] = wd; psel[d] = 1'b1; penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    // Bus values during ACCESS must not matter.
    paddr[d] = AW'($urandom); pwrite[d] = 1'($urandom); pwdata[d] = $urandom;
    waits = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1;
        comp_cyc = cyc;
        rd = prdata[d];
        n_cmp++;
        if (waits !== wait_of(d)) begin
          n_bad++; $display("FAIL wait_count dut%0d: got %0d want %0d", d, waits, wait_of(d));
        end
        n_cmp++;
        if (comp_cyc - setup_cyc !== wait_of(d) + 1) begin
          n_bad++;
          $display("FAIL setup_to_completion dut%0d: got %0d want %0d", d,
                   comp_cyc - setup_cyc, wait_of(d) + 1);
        end
        n_cmp++;
        if (pslverr[d] !== err) begin
          n_bad++; $display("FAIL pslverr dut%0d addr %h: got %b want %b", d, a, pslverr[d], err);
        end
        n_cmp++;
        if (prdata[d] !== exp_rd) begin
          n_bad++; $display("FAIL prdata dut%0d addr %h: got %h want %h", d, a, prdata[d], exp_rd);
        end
      end else begin
        waits++;
        n_cmp++;
        if (pslverr[d] !== 1'b0 || prdata[d] !== 32'd0) begin
          n_bad++;
          $display("FAIL wait_outputs dut%0d: pslverr %b prdata %h want 0 0", d, pslverr[d],
                   prdata[d]);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout dut%0d addr %h: got no PREADY want PREADY", d, a);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    if (done && wr && !err) model[d][idx] = wd;
    @(negedge clk);
    n_cmp++;
    if (wr_stb[d] !== (done && wr && !err)) begin
      n_bad++;
      $display("FAIL wr_stb dut%0d addr %h: got %b want %b", d, a, wr_stb[d], done && wr && !err);
    end
    if (done && wr && !err) begin
      n_cmp++;
      if (wr_idx[d] !== 8'(idx)) begin
        n_bad++; $display("FAIL wr_idx dut%0d: got %0d want %0d", d, wr_idx[d], idx);
      end
    end
    n_cmp++;
    if (regs[d] !== image(d)) begin
      n_bad++; $display("FAIL regs dut%0d: got %h want %h", d, regs[d], image(d));
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0;
      for (int k = 0; k < int'(NR); k++) model[d][k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({pready[d], pslverr[d], prdata[d], wr_stb[d], wr_idx[d]} !== 43'd0 ||
          regs[d] !== '0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: rdy %b err %b rd %h stb %b idx %0d want all 0", d,
                 pready[d], pslverr[d], prdata[d], wr_stb[d], wr_idx[d]);
      end
      rst[d] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_fill_and_read();
    logic [31:0] rd;
    int c;
    int base;
    base = stb_cnt0;
    for (int i = 0; i < int'(NR); i++) xfer(0, 1'b1, AW'(i * 4), 32'(10 + 2 * i), rd, c);
    for (int i = 0; i < int'(NR); i++) begin
      xfer(0, 1'b0, AW'(i * 4), 32'd0, rd, c);
      n_cmp++;
      if (rd !== 32'(10 + 2 * i)) begin
        n_bad++; $display("FAIL fill_read idx %0d: got %0d want %0d", i, rd, 10 + 2 * i);
      end
    end
    n_cmp++;
    if (stb_cnt0 - base !== int'(NR)) begin
      n_bad++; $display("FAIL stb_pulses: got %0d want %0d", stb_cnt0 - base, NR);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int c;
    xfer(1, 1'b1, AW'('h08), 32'hDEAD_BEEF, rd, c);
    n_cmp++;
    if (regs[1][95:64] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL reg2_image: got %h want deadbeef", regs[1][95:64]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    int c;
    xfer(0, 1'b1, AW'('h50), 32'h1234_5678, rd, c);
    xfer(0, 1'b1, AW'('h06), 32'h8765_4321, rd, c);
    xfer(0, 1'b0, AW'('h3FC), 32'd0, rd, c);
    xfer(2, 1'b0, AW'('h51), 32'd0, rd, c);
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int c;
    paddr[2] = AW'('h04); pwrite[2] = 1'b1; pwdata[2] = 32'h55; psel[2] = 1'b1; penable[2] = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pready[2] !== 1'b0 || wr_stb[2] !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_quiet cyc %0d: rdy %b stb %b want 0 0", i, pready[2], wr_stb[2]);
      end
    end
    n_cmp++;
    if (regs[2] !== image(2)) begin
      n_bad++; $display("FAIL abort_regs: got %h want %h", regs[2], image(2));
    end
    xfer(2, 1'b1, AW'('h04), 32'h99, rd, c);
    xfer(2, 1'b0, AW'('h04), 32'd0, rd, c);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int c1;
    int c2;
    xfer(0, 1'b1, AW'('h00), 32'd1, rd, c1);
    xfer(0, 1'b0, AW'('h00), 32'd0, rd, c2);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_bad++; $display("FAIL b2b_read: got %h want 1", rd);
    end
    n_cmp++;
    if (c2 - c1 !== 2) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d want 2", c2 - c1);
    end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd;
    int c;
    paddr[1] = AW'('h0C); pwrite[1] = 1'b1; pwdata[1] = 32'h77; psel[1] = 1'b1;
    penable[1] = 1'b0;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pready[1] !== 1'b1) begin
      n_bad++; $display("FAIL rst_cycle_ready: got %b want 1", pready[1]);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    for (int k = 0; k < int'(NR); k++) model[1][k] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({pready[1], pslverr[1], prdata[1], wr_stb[1], wr_idx[1]} !== 43'd0 ||
          regs[1] !== '0) begin
        n_bad++;
        $display("FAIL rst_abort cyc %0d: rdy %b err %b rd %h stb %b idx %0d reg3 %h want 0", i,
                 pready[1], pslverr[1], prdata[1], wr_stb[1], wr_idx[1], regs[1][127:96]);
      end
    end
    xfer(1, 1'b0, AW'('h0C), 32'd0, rd, c);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int c;
    int d;
    for (int n = 0; n < 60; n++) begin
      d = ($urandom_range(0, 1) == 0) ? 0 : 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(d, 1'($urandom), AW'($urandom_range(0, 95)), $urandom, rd, c);
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_read();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_in_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
